// File: rtl/key_debounce_sched_if.sv
// ---------------------------------------------------------------------------
// key_debounce_sched_if
// Bundles the key inputs and the debounced outputs of key_debounce_sched.
//   key_raw   : raw asynchronous key levels (driven by the master side)
//   key_state : debounced key levels
//   key_press : one-cycle pulse per debounced 0->1 transition
//   busy      : shared delay counter is owned (WAIT or COMMIT)
//   owner     : index of the current or last owning key
//   fsm_state : encoded scheduler state for debug
// Modports: master = key source / observer, slave = the debouncer.
// ---------------------------------------------------------------------------
interface key_debounce_sched_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic              busy;
  logic [2:0]        owner;
  logic [1:0]        fsm_state;

  modport master (
    output key_raw,
    input  key_state,
    input  key_press,
    input  busy,
    input  owner,
    input  fsm_state
  );

  modport slave (
    input  key_raw,
    output key_state,
    output key_press,
    output busy,
    output owner,
    output fsm_state
  );
endinterface

// File: rtl/key_debounce_sched.sv
// ---------------------------------------------------------------------------
// key_debounce_sched
// Debounces N_KEYS keys with a single shared delay counter. A key whose
// synchronized level differs from its debounced level is granted the counter
// (round-robin from the key after the last owner); if it stays different for
// DLY_MAX clocks its debounced level is committed, otherwise the attempt is
// aborted and the key goes back into the pending pool.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : key_debounce_sched_if.slave (key_raw in; key_state, key_press,
//         busy, owner, fsm_state out)
// ---------------------------------------------------------------------------
module key_debounce_sched #(
  parameter int N_KEYS  = 4,
  parameter int DLY_W   = 21,
  parameter int DLY_MAX = 2**20
) (
  input logic                   clk,
  input logic                   rst,
  key_debounce_sched_if.slave   bus
);

  localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam logic [DLY_W-1:0] DLY_MAX_C = DLY_W'(DLY_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_KEYS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;

  state_t            state_reg;
  logic [DLY_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  owner_reg;
  logic [IDX_W-1:0]  last_owner_reg;
  logic [N_KEYS-1:0] key_state_reg;
  logic [N_KEYS-1:0] key_press_reg;
  logic              busy_reg;

  logic [N_KEYS-1:0] ksync;
  logic [N_KEYS-1:0] mismatch;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;

  // Two-flop synchronizer per key; key_raw is asynchronous.
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= bus.key_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign ksync[gi] = sync_reg;
    end
  endgenerate

  // Keys whose synchronized level disagrees with the debounced level.
  assign mismatch = ksync ^ key_state_reg;

  // Round-robin search starting just after the last owner, so a key that was
  // just served (or just aborted) yields to the other pending keys.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cand = IDX_W'((int'(last_owner_reg) + 1 + i) % N_KEYS);
      if (!grant_valid && mismatch[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      owner_reg      <= '0;
      last_owner_reg <= LAST_IDX;
      key_state_reg  <= '0;
      key_press_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      key_press_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_reg <= grant_idx;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A bounce back to the committed level wins over terminal count.
          if (!mismatch[owner_reg]) begin
            cnt_reg        <= '0;
            last_owner_reg <= owner_reg;
            busy_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
          end else if (cnt_reg == DLY_MAX_C) begin
            state_reg <= ST_COMMIT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_COMMIT: begin
          key_state_reg[owner_reg] <= ksync[owner_reg];
          // Pulse only on a real 0->1 change of the debounced level.
          key_press_reg[owner_reg] <= ksync[owner_reg] & ~key_state_reg[owner_reg];
          last_owner_reg <= owner_reg;
          cnt_reg        <= '0;
          busy_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: begin
          // Unused encoding 2'b11: recover to IDLE.
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.key_state = key_state_reg;
  assign bus.key_press = key_press_reg;
  assign bus.busy      = busy_reg;
  assign bus.owner     = 3'(owner_reg);
  assign bus.fsm_state = state_reg;

endmodule

// File: tb/tb_key_debounce_sched.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_sched
// Directed bench for key_debounce_sched with N_KEYS = 4, DLY_MAX = 8.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point. Edge k = 1 is the first rising edge that sees a new key_raw level.
// ---------------------------------------------------------------------------
module tb_key_debounce_sched;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  key_debounce_sched_if #(.N_KEYS(4)) bus ();

  key_debounce_sched #(
    .N_KEYS (4),
    .DLY_W  (8),
    .DLY_MAX(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.key_raw = 4'b0000;
    do_reset();
    rst = 1'b1;
    bus.key_raw = 4'b1111;
    step();
    checks++;
    if (bus.key_state !== 4'b0000 || bus.key_press !== 4'b0000) begin
      errors++;
      $display("FAIL reset_keys: state=%b press=%b, required 0000/0000", bus.key_state, bus.key_press);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.owner !== 3'd0 || bus.fsm_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b owner=%0d fsm=%b, required 0/0/00", bus.busy, bus.owner, bus.fsm_state);
    end
    bus.key_raw = 4'b0000;
    step();
    rst = 1'b0;
    step();
    step();
    $display("reset: state=%b press=%b busy=%b fsm=%b", bus.key_state, bus.key_press, bus.busy, bus.fsm_state);
  endtask

  task automatic test_clean_press();
    int busy_cnt = 0;
    int press_cnt = 0;
    bus.key_raw = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.key_press !== 4'b0000) press_cnt++;
      if (k == 3) begin
        checks++;
        if (bus.fsm_state !== 2'b01 || bus.owner !== 3'd0) begin
          errors++;
          $display("FAIL press_grant: fsm=%b owner=%0d, required 01/0", bus.fsm_state, bus.owner);
        end
      end
      if (k == 12) begin
        checks++;
        if (bus.key_state !== 4'b0000 || bus.fsm_state !== 2'b10) begin
          errors++;
          $display("FAIL press_early: state=%b fsm=%b, required 0000/10", bus.key_state, bus.fsm_state);
        end
      end
      if (k == 13) begin
        checks++;
        if (bus.key_state !== 4'b0001 || bus.key_press !== 4'b0001) begin
          errors++;
          $display("FAIL press_commit: state=%b press=%b, required 0001/0001", bus.key_state, bus.key_press);
        end
      end
    end
    checks++;
    if (busy_cnt != 10) begin
      errors++;
      $display("FAIL press_busy: busy cycles=%0d, required 10", busy_cnt);
    end
    checks++;
    if (press_cnt != 1) begin
      errors++;
      $display("FAIL press_pulses: pulse cycles=%0d, required 1", press_cnt);
    end
    $display("clean_press: state=%b busy_cycles=%0d pulses=%0d", bus.key_state, busy_cnt, press_cnt);
  endtask

  task automatic test_release();
    int press_cnt = 0;
    bus.key_raw = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.key_press !== 4'b0000) press_cnt++;
      if (k == 12) begin
        checks++;
        if (bus.key_state !== 4'b0001) begin
          errors++;
          $display("FAIL release_early: state=%b, required 0001", bus.key_state);
        end
      end
      if (k == 13) begin
        checks++;
        if (bus.key_state !== 4'b0000) begin
          errors++;
          $display("FAIL release_commit: state=%b, required 0000", bus.key_state);
        end
      end
    end
    checks++;
    if (press_cnt != 0) begin
      errors++;
      $display("FAIL release_pulse: pulse cycles=%0d, required 0", press_cnt);
    end
    $display("release: state=%b pulses=%0d", bus.key_state, press_cnt);
  endtask

  task automatic test_bounce();
    int press_cnt = 0;
    int busy_cnt = 0;
    bus.key_raw = 4'b0010;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 4) bus.key_raw = 4'b0000;
      if (bus.key_press !== 4'b0000) press_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (press_cnt != 0 || bus.key_state !== 4'b0000 || bus.fsm_state !== 2'b00) begin
      errors++;
      $display("FAIL bounce_abort: pulses=%0d state=%b fsm=%b, required 0/0000/00", press_cnt, bus.key_state, bus.fsm_state);
    end
    checks++;
    if (busy_cnt == 0 || busy_cnt >= 10) begin
      errors++;
      $display("FAIL bounce_busy: busy cycles=%0d, required 1..9", busy_cnt);
    end
    bus.key_raw = 4'b0010;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 13) begin
        checks++;
        if (bus.key_state !== 4'b0010 || bus.key_press !== 4'b0010) begin
          errors++;
          $display("FAIL bounce_recommit: state=%b press=%b, required 0010/0010", bus.key_state, bus.key_press);
        end
      end
    end
    $display("bounce: aborted busy_cycles=%0d, recommit state=%b", busy_cnt, bus.key_state);
  endtask

  task automatic test_contention();
    int stray = 0;
    bus.key_raw = 4'b0000;
    do_reset();
    bus.key_raw = 4'b1010;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 13) begin
        checks++;
        if (bus.key_press !== 4'b0010 || bus.owner !== 3'd1) begin
          errors++;
          $display("FAIL contend_first: press=%b owner=%0d, required 0010/1", bus.key_press, bus.owner);
        end
      end else if (k == 24) begin
        checks++;
        if (bus.key_press !== 4'b1000 || bus.owner !== 3'd3) begin
          errors++;
          $display("FAIL contend_second: press=%b owner=%0d, required 1000/3", bus.key_press, bus.owner);
        end
      end else if (bus.key_press !== 4'b0000) begin
        stray++;
      end
    end
    checks++;
    if (stray != 0 || bus.key_state !== 4'b1010) begin
      errors++;
      $display("FAIL contend_final: stray=%0d state=%b, required 0/1010", stray, bus.key_state);
    end
    $display("contention: state=%b stray_pulses=%0d", bus.key_state, stray);
  endtask

  task automatic test_fairness();
    int stray = 0;
    bus.key_raw = 4'b0011;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 13) begin
        checks++;
        if (bus.key_press !== 4'b0001 || bus.owner !== 3'd0) begin
          errors++;
          $display("FAIL fair_first: press=%b owner=%0d, required 0001/0", bus.key_press, bus.owner);
        end
      end else if (bus.key_press !== 4'b0000) begin
        stray++;
      end
      if (k == 23) begin
        checks++;
        if (bus.key_state !== 4'b1011) begin
          errors++;
          $display("FAIL fair_mid: state=%b, required 1011", bus.key_state);
        end
      end
      if (k == 24) begin
        checks++;
        if (bus.key_state !== 4'b0011 || bus.owner !== 3'd3) begin
          errors++;
          $display("FAIL fair_second: state=%b owner=%0d, required 0011/3", bus.key_state, bus.owner);
        end
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL fair_stray: stray pulses=%0d, required 0", stray);
    end
    $display("fairness: state=%b stray_pulses=%0d", bus.key_state, stray);
  endtask

  task automatic test_reset_mid_wait();
    int press_cnt = 0;
    bus.key_raw = 4'b0000;
    do_reset();
    bus.key_raw = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus.key_press !== 4'b0000) press_cnt++;
    end
    checks++;
    if (bus.fsm_state !== 2'b01 || bus.owner !== 3'd2) begin
      errors++;
      $display("FAIL midrst_wait: fsm=%b owner=%0d, required 01/2", bus.fsm_state, bus.owner);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.key_state !== 4'b0000 || bus.key_press !== 4'b0000 || bus.busy !== 1'b0 ||
        bus.owner !== 3'd0 || bus.fsm_state !== 2'b00 || press_cnt != 0) begin
      errors++;
      $display("FAIL midrst_clear: state=%b press=%b busy=%b owner=%0d fsm=%b pulses=%0d, required all 0",
               bus.key_state, bus.key_press, bus.busy, bus.owner, bus.fsm_state, press_cnt);
    end
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 12) begin
        checks++;
        if (bus.key_state !== 4'b0000 || bus.key_press !== 4'b0000) begin
          errors++;
          $display("FAIL midrst_early: state=%b press=%b, required 0000/0000", bus.key_state, bus.key_press);
        end
      end
      if (k == 13) begin
        checks++;
        if (bus.key_state !== 4'b0100 || bus.key_press !== 4'b0100) begin
          errors++;
          $display("FAIL midrst_recommit: state=%b press=%b, required 0100/0100", bus.key_state, bus.key_press);
        end
      end
    end
    $display("reset_mid_wait: state=%b", bus.key_state);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.key_raw = 4'b0000;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_contention();
    test_fairness();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce_sched.md
KEY_DEBOUNCE_SCHED -- requirements
Module: key_debounce_sched

Interface
REQ-001 Parameter N_KEYS, default 4: number of key requesters; legal values 2..8.
REQ-002 Parameter DLY_W, default 21: width of the shared delay counter.
REQ-003 Parameter DLY_MAX, default 2**20: stability interval in clocks; must satisfy 1 <= DLY_MAX < 2**DLY_W.
REQ-004 clk  in  1: single clock, all state updates on its rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 key_raw  in  N_KEYS: asynchronous raw key levels, one per requester.
REQ-007 key_state  out  N_KEYS: debounced key levels.
REQ-008 key_press  out  N_KEYS: one-cycle pulse per debounced 0->1 transition.
REQ-009 busy  out  1: high while the shared delay counter is owned (WAIT or COMMIT).
REQ-010 owner  out  3: index of the current or last owning key.
REQ-011 fsm_state  out  2: encoded FSM state for debug.

Function
REQ-012 Each key_raw bit SHALL pass through a 2-flop synchronizer (ksync) before any other use.
REQ-013 The mismatch vector SHALL be m = ksync ^ key_state, evaluated every cycle.
REQ-014 The FSM SHALL use exactly three states: IDLE = 2'b00, WAIT = 2'b01, COMMIT = 2'b10; 2'b11 is illegal and SHALL return to IDLE on the next edge.
REQ-015 IDLE: if m != 0, the block SHALL grant the first set bit of m, searching round-robin from last_owner+1 (mod N_KEYS); load owner, clear the counter, go to WAIT; if m == 0, stay in IDLE.
REQ-016 WAIT: the counter SHALL increment by 1 per cycle (DLY_W bits, no wrap ever reached).
REQ-017 WAIT: if m[owner] == 0 (bounce back), the block SHALL abort: clear the counter, set last_owner = owner, return to IDLE; key_state is unchanged and no pulse is issued.
REQ-018 WAIT: abort SHALL take precedence over the terminal count.
REQ-019 WAIT: when the counter == DLY_MAX and no abort occurs, the FSM SHALL go to COMMIT.
REQ-020 COMMIT: on the next edge, key_state[owner] SHALL take ksync[owner], key_press[owner] SHALL be 1 for exactly one cycle if the new value is 1, last_owner SHALL take owner, the counter SHALL clear, and the FSM SHALL return to IDLE.
REQ-021 At most one key_press bit SHALL be high in any cycle; key_press SHALL be registered.
REQ-022 Changes on keys not owned SHALL NOT affect the counter; these keys remain pending in m and are served in round-robin order afterwards.
REQ-023 Latency for a clean edge with the block idle SHALL be DLY_MAX+5 rising edges from the first edge sampling the new key_raw level to key_state/key_press visible.
REQ-024 A 1->0 transition SHALL follow the same path and update key_state, with no key_press pulse.
REQ-025 busy SHALL be 1 exactly when the FSM is in WAIT or COMMIT.

Reset
REQ-026 While rst = 1 at a clock edge, the FSM SHALL go to IDLE and the counter, ksync, key_state, key_press, owner and busy SHALL all be 0; last_owner SHALL be N_KEYS-1.
REQ-027 Reset asserted mid-WAIT or mid-COMMIT SHALL discard the pending update with no key_press pulse; rst SHALL override all other conditions.

Verification (DLY_MAX = 8, N_KEYS = 4)
REQ-028 Clean press: key_raw = 4'b0001, held -> key_state[0] = 1 and key_press = 4'b0001 for one cycle, 13 edges after the first sampling edge; busy high for 10 cycles.
REQ-029 Bounce: key_raw[1] high for 4 cycles then low -> abort, key_state = 0, no pulse, FSM back to IDLE; re-asserting and holding key_raw[1] later commits normally.
REQ-030 Contention: key_raw = 4'b1010 set simultaneously from reset -> key 1 served first, key 3 second; key_press pulses 4'b0010 then 4'b1000, separated by DLY_MAX+3 cycles.
REQ-031 Fairness: after key 3 commits, key_raw bits 0 and 3 toggle together -> key 0 is granted before key 3.
REQ-032 Release: a held key 0 is released -> key_state[0] falls after 13 edges, key_press stays 0.
REQ-033 Reset mid-WAIT: rst pulsed at counter = 5 -> all outputs 0 and no pulse; the still-held key then recommits with full latency.
